// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported 16-bit memory between the
// instruction-fetch port (read-only) and the data port (read/write).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [15:0]           i_rdata,
  output logic                  i_valid,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic [15:0]           d_rdata,
  output logic                  d_valid,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: LATENCY must be in 1..15");
  end

  // Handshake: a requester raises req with stable addr/wr/wdata and holds them
  // until its valid pulse; the request is retired in that valid cycle.
  logic [1:0]            state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  owner_d_q, owner_d_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [15:0]           i_rdata_q, i_rdata_d;
  logic [15:0]           d_rdata_q, d_rdata_d;
  logic                  grant_d;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    owner_d_d = owner_d_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie the port that did not win last time is served.
        grant_d = d_req & (~i_req | ~last_d_q);
        if (i_req | d_req) begin
          owner_d_d = grant_d;
          last_d_d  = grant_d;
          addr_d    = grant_d ? {d_addr[ADDR_WIDTH-1:1], 1'b0}
                              : {i_addr[ADDR_WIDTH-1:1], 1'b0};
          wr_d      = grant_d & d_wr;
          wdata_d   = d_wdata;
          cnt_d     = CNT_INIT;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!wr_q) begin
            if (owner_d_q) d_rdata_d = mem_data_out;
            else           i_rdata_d = mem_data_out;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_d_q  <= 1'b1;
      owner_d_q <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= 16'h0000;
      cnt_q     <= 4'd0;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      owner_d_q <= owner_d_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // The write strobe is qualified by the final count so each write hits one edge.
  assign mem_enable  = (state_q == ST_BUSY);
  assign mem_wr      = (state_q == ST_BUSY) && wr_q && (cnt_q == 4'd0);
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign i_valid     = (state_q == ST_DONE) && !owner_d_q;
  assign d_valid     = (state_q == ST_DONE) && owner_d_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q == ST_BUSY) || (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (LATENCY 1 and 4), each with
// its own word-addressed memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_req[2], d_req[2], d_wr[2];
  logic [15:0] i_addr[2], d_addr[2], d_wdata[2];
  logic [15:0] i_rdata[2], d_rdata[2];
  logic        i_valid[2], d_valid[2];
  logic        mem_enable[2], mem_wr[2], busy[2];
  logic [15:0] mem_addr[2], mem_data_in[2], mem_data_out[2];
  logic [1:0]  dbg_state[2];
  logic [15:0] mem[2][0:255];
  int          wr_cnt[2];
  int          lat[2] = '{1, 4};
  int          both_seen = 0;

  int vectors = 0;
  int miscompares = 0;

  logic        pl_en = 1'b0;
  int          pl_s;
  logic [7:0]  pl_idx;
  logic [15:0] pl_data;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_valid(i_valid[g]),
      .d_req(d_req[g]), .d_wr(d_wr[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_valid(d_valid[g]),
      .mem_enable(mem_enable[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
      .mem_data_in(mem_data_in[g]), .mem_data_out(mem_data_out[g]),
      .busy(busy[g]), .dbg_state(dbg_state[g])
    );
    assign mem_data_out[g] = mem[g][mem_addr[g][8:1]];
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_s][pl_idx] <= pl_data;
    for (int s = 0; s < 2; s++) begin
      if (mem_enable[s] && mem_wr[s]) begin
        mem[s][mem_addr[s][8:1]] <= mem_data_in[s];
        wr_cnt[s] <= wr_cnt[s] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++)
      if (i_valid[s] && d_valid[s]) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int s, input logic [7:0] idx, input logic [15:0] data);
    @(posedge clk); #1;
    pl_s = s; pl_idx = idx; pl_data = data; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One full request on instance s; optionally retargets d_addr in cycle 1.
  task automatic access(input int s, input bit port_d, input bit wr,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp, input bit chg,
                        input logic [15:0] alt, input string tag);
    int k, en, bz, ov, w0;
    bit got;
    @(posedge clk); #1;
    if (port_d) begin
      d_req[s] = 1'b1; d_wr[s] = wr; d_addr[s] = addr; d_wdata[s] = wdata;
    end else begin
      i_req[s] = 1'b1; i_addr[s] = addr;
    end
    w0 = wr_cnt[s]; k = 0; en = 0; bz = 0; ov = 0; got = 1'b0;
    while (!got && k <= 40) begin
      @(negedge clk);
      if (mem_enable[s]) begin
        en++;
        check({tag, "_maddr"}, 32'(mem_addr[s]), 32'({addr[15:1], 1'b0}));
      end
      if (busy[s]) bz++;
      if (port_d ? i_valid[s] : d_valid[s]) ov++;
      if (port_d ? d_valid[s] : i_valid[s]) got = 1'b1;
      else begin
        if (chg && k == 1) d_addr[s] = alt;
        k++;
      end
    end
    check({tag, "_latency"}, 32'(k), 32'(lat[s] + 1));
    check({tag, "_en_cycles"}, 32'(en), 32'(lat[s]));
    check({tag, "_busy_cycles"}, 32'(bz), 32'(lat[s] + 1));
    check({tag, "_other_valid"}, 32'(ov), 32'd0);
    check({tag, "_writes"}, 32'(wr_cnt[s] - w0), 32'(wr));
    if (!wr) check({tag, "_rdata"}, 32'(port_d ? d_rdata[s] : i_rdata[s]), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(port_d ? d_valid[s] : i_valid[s]), 32'd0);
    i_req[s] = 1'b0; d_req[s] = 1'b0; d_wr[s] = 1'b0;
  endtask

  initial begin
    int n, k, dv, w0;
    int who[4], when[4];
    int exp_t[4] = '{2, 5, 8, 11};
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      i_req[s] = 1'b0; d_req[s] = 1'b0; d_wr[s] = 1'b0;
      i_addr[s] = 16'h0; d_addr[s] = 16'h0; d_wdata[s] = 16'h0;
    end
    preload(0, 8'h08, 16'hBEEF);
    preload(1, 8'h20, 16'hCAFE);
    preload(1, 8'h30, 16'hAAAA);
    preload(1, 8'h08, 16'h1357);
    for (int s = 0; s < 2; s++) begin
      check("rst_i_rdata", 32'(i_rdata[s]), 32'h0);
      check("rst_d_rdata", 32'(d_rdata[s]), 32'h0);
      check("rst_valids", 32'({i_valid[s], d_valid[s]}), 32'h0);
      check("rst_mem_en", 32'({mem_enable[s], mem_wr[s]}), 32'h0);
      check("rst_busy", 32'(busy[s]), 32'h0);
      check("rst_state", 32'(dbg_state[s]), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    access(0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 16'h0, "i_rd");
    access(0, 1'b1, 1'b1, 16'h0022, 16'h1234, 16'h0, 1'b0, 16'h0, "d_wr");
    access(0, 1'b1, 1'b0, 16'h0023, 16'h0, 16'h1234, 1'b0, 16'h0, "d_rd_odd");
    check("i_rdata_hold", 32'(i_rdata[0]), 32'hBEEF);

    // Both ports held together straight out of reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_req[0] = 1'b1; i_addr[0] = 16'h0010;
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0022;
    n = 0; k = 0;
    while (n < 4 && k < 40) begin
      @(negedge clk);
      if (i_valid[0]) begin who[n] = 0; when[n] = k; n++; end
      else if (d_valid[0]) begin who[n] = 1; when[n] = k; n++; end
      k++;
    end
    @(posedge clk); #1;
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    check("rr_count", 32'(n), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check("rr_owner", 32'(j < n ? who[j] : -1), 32'(j % 2));
      check("rr_time", 32'(j < n ? when[j] : -1), 32'(exp_t[j]));
    end
    check("rr_i_rdata", 32'(i_rdata[0]), 32'hBEEF);
    check("rr_d_rdata", 32'(d_rdata[0]), 32'h1234);

    access(1, 1'b1, 1'b0, 16'h0040, 16'h0, 16'hCAFE, 1'b0, 16'h0, "d_rd_l4");

    // Abort a LATENCY=4 write two cycles into BUSY.
    @(posedge clk); #1;
    d_req[1] = 1'b1; d_wr[1] = 1'b1; d_addr[1] = 16'h0060; d_wdata[1] = 16'h5555;
    w0 = wr_cnt[1];
    repeat (3) @(negedge clk);
    check("abort_in_busy", 32'(dbg_state[1]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_en", 32'({mem_enable[1], mem_wr[1]}), 32'h0);
    check("abort_busy", 32'(busy[1]), 32'h0);
    check("abort_valid", 32'(d_valid[1]), 32'h0);
    d_req[1] = 1'b0; d_wr[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dv = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_valid[1]) dv++;
    end
    check("abort_no_valid", 32'(dv), 32'd0);
    check("abort_word", 32'(mem[1][8'h30]), 32'hAAAA);
    check("abort_writes", 32'(wr_cnt[1] - w0), 32'd0);
    access(1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h1357, 1'b0, 16'h0, "i_after_abort");

    access(1, 1'b1, 1'b0, 16'h0040, 16'h0, 16'hCAFE, 1'b1, 16'h0060, "d_addr_chg");
    access(1, 1'b1, 1'b0, 16'h0060, 16'h0, 16'hAAAA, 1'b0, 16'h0, "d_next_addr");

    check("no_dual_valid", 32'(both_seen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
